// File: rtl/feature_serializer.sv
// rtl/feature_serializer.sv - FIFO-buffered parallel-to-serial channel streamer with frame tracking
module feature_serializer #(
  parameter int          DATA_WIDHT = 32,
  parameter int          NUM_CH     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IMG_WIDTH  = 32'd44,
  parameter logic [31:0] IMG_HEIGHT = 32'd44
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDHT*NUM_CH-1:0] Data_In,
  input  logic                         Valid_In,
  output logic [DATA_WIDHT-1:0]        Data_Out,
  output logic [$clog2(NUM_CH)-1:0]    Ch_Idx,
  output logic                         Valid_Out,
  input  logic                         Ready_In,
  output logic                         Last_Out,
  output logic                         Overflow,
  output logic                         Busy
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      PIX     = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                         state;
  logic [DATA_WIDHT*NUM_CH-1:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDHT*NUM_CH-1:0]   head;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [CNT_W-1:0]               count;
  logic [CH_W-1:0]                ch_idx;
  logic [31:0]                    pix_cnt;
  logic                           overflow_r;
  logic                           xfer, pop, wr;

  assign Valid_Out = (count != '0);
  assign xfer      = Valid_Out && Ready_In;
  assign pop       = xfer && (ch_idx == LAST_CH);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign wr        = Valid_In && ((count != DEPTH_C) || pop);

  assign head      = mem[rd_ptr];
  assign Ch_Idx    = ch_idx;
  assign Overflow  = overflow_r;
  assign Busy      = (state == STREAM);
  assign Last_Out  = Valid_Out && (ch_idx == LAST_CH) && (pix_cnt == PIX - 32'd1);

  always_comb begin
    Data_Out = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx == CH_W'(k)) Data_Out = head[k*DATA_WIDHT +: DATA_WIDHT];
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= Data_In;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ch_idx     <= '0;
      pix_cnt    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (Valid_In && !wr) overflow_r <= 1'b1;
      if (xfer) ch_idx <= pop ? '0 : ch_idx + CH_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        pix_cnt <= (pix_cnt == PIX - 32'd1) ? '0 : pix_cnt + 32'd1;
      end
      case ({wr, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE:    if (wr) state <= STREAM;
        STREAM:  if (pop && !wr && count == CNT_W'(1)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_serializer.sv
// tb/tb_feature_serializer.sv - scoreboard bench for feature_serializer
module tb_feature_serializer;
  localparam int DW = 32, NC = 8, DEPTH = 4, PIX = 44 * 44;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    ch;
    logic          last;
  } smp_t;

  logic            clk = 1'b0, rst = 1'b0;
  logic [DW*NC-1:0] Data_In = '0;
  logic            Valid_In = 1'b0, Ready_In = 1'b0;
  logic [DW-1:0]   Data_Out;
  logic [2:0]      Ch_Idx;
  logic            Valid_Out, Last_Out, Overflow, Busy;

  smp_t exp_q[$];
  smp_t mon_e;
  int   checks = 0, failures = 0, last_xfers = 0;
  int   occ = 0, cur_ch = 0, widx = 0;
  bit   ovf = 1'b0;
  logic [DW*NC-1:0] w10;

  always #5 clk = ~clk;

  feature_serializer #(.DATA_WIDHT(DW), .NUM_CH(NC), .FIFO_DEPTH(DEPTH),
                       .IMG_WIDTH(32'd44), .IMG_HEIGHT(32'd44)) dut (
    .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In),
    .Data_Out(Data_Out), .Ch_Idx(Ch_Idx), .Valid_Out(Valid_Out),
    .Ready_In(Ready_In), .Last_Out(Last_Out), .Overflow(Overflow), .Busy(Busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW*NC-1:0] rnd_word();
    logic [DW*NC-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    occ = 0; cur_ch = 0; widx = 0; ovf = 1'b0;
  endtask

  // One clock of stimulus; the model decides acceptance from occupancy and channel position.
  task automatic cyc(input bit v, input logic [DW*NC-1:0] d, input bit r);
    bit   popping, accept;
    smp_t s;
    Valid_In = v; Data_In = d; Ready_In = r;
    popping = (occ > 0) && r && (cur_ch == NC - 1);
    accept  = v && ((occ < DEPTH) || popping);
    if (accept) begin
      for (int k = 0; k < NC; k++) begin
        s.d    = d[k*DW +: DW];
        s.ch   = k[2:0];
        s.last = (k == NC - 1) && ((widx % PIX) == PIX - 1);
        exp_q.push_back(s);
      end
      widx++;
    end
    if (v && !accept) ovf = 1'b1;
    @(posedge clk);
    if (occ > 0 && r) cur_ch = (cur_ch + 1) % NC;
    occ = occ + int'(accept) - int'(popping);
    #1;
    chk("valid_out", Valid_Out, occ != 0);
    chk("busy", Busy, occ != 0);
    chk("overflow", Overflow, ovf);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    Valid_In = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_valid_out", Valid_Out, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_last_out", Last_Out, 0);
    chk("rst_overflow", Overflow, 0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && Valid_Out) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: actual data=%0h ch=%0d required=none", Data_Out, Ch_Idx);
      end else begin
        mon_e = exp_q[0];
        chk("data_out", Data_Out, mon_e.d);
        chk("ch_idx", Ch_Idx, mon_e.ch);
        chk("last_out", Last_Out, mon_e.last);
        if (Ready_In) begin
          void'(exp_q.pop_front());
          if (Last_Out) last_xfers++;
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NC; k++) w10[k*DW +: DW] = 32'h10 + k;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_out", Valid_Out, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_overflow", Overflow, 0);
    chk("reset_last_out", Last_Out, 0);
    rst = 1'b1;

    // single word
    cyc(1'b1, w10, 1'b1);
    repeat (12) cyc(1'b0, '0, 1'b1);
    chk("single_drained", exp_q.size(), 0);

    // backpressure at channel 3
    cyc(1'b1, w10, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    repeat (5) cyc(1'b0, '0, 1'b0);
    chk("bp_hold_ch", Ch_Idx, 3);
    chk("bp_hold_data", Data_Out, 32'h13);
    drain();

    // overflow: six writes into a depth-4 FIFO with no pops
    repeat (6) cyc(1'b1, rnd_word(), 1'b0);
    chk("ovf_set", Overflow, 1);
    drain();
    chk("ovf_sticky", Overflow, 1);
    apply_reset();

    // full FIFO with write on the channel-7 pop edge
    repeat (4) cyc(1'b1, rnd_word(), 1'b0);
    repeat (7) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, rnd_word(), 1'b1);
    chk("fullpop_no_ovf", Overflow, 0);
    cyc(1'b1, rnd_word(), 1'b0);
    chk("fullpop_count_full", Overflow, 1);
    drain();
    apply_reset();

    // full frame plus first word of the next frame
    last_xfers = 0;
    for (int i = 0; i < PIX + 1; i++) begin
      cyc(1'b1, rnd_word(), 1'b1);
      repeat (NC - 1) cyc(1'b0, '0, 1'b1);
    end
    drain();
    chk("frame_last_count", last_xfers, 1);
    chk("frame_no_ovf", Overflow, 0);
    apply_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 3) == 0, rnd_word(), ($urandom % 4) != 0);
    drain();

    // mid-frame reset with 3 words buffered at channel 5
    repeat (3) cyc(1'b1, rnd_word(), 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("mr_ch_before", Ch_Idx, 5);
    apply_reset();
    cyc(1'b1, w10, 1'b1);
    chk("mr_first_ch", Ch_Idx, 0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/feature_serializer.md
FEATURE_SERIALIZER -- requirements
Module: feature_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDHT, default 32, the width of one channel sample.
REQ-002 SHALL have parameter NUM_CH, default 8, the number of channels per input word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the number of input words buffered (power of 2, >=2).
REQ-004 SHALL have parameters IMG_WIDTH and IMG_HEIGHT, default 32'd44 each, the pixels per frame (PIX = IMG_WIDTH*IMG_HEIGHT).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port Data_In, input, DATA_WIDHT*NUM_CH, the parallel channel word; channel k at bits [k*DATA_WIDHT +: DATA_WIDHT].
REQ-008 SHALL have port Valid_In, input, 1, Data_In valid this cycle; there is no backpressure to the upstream producer.
REQ-009 SHALL have port Data_Out, output, DATA_WIDHT, the current channel sample.
REQ-010 SHALL have port Ch_Idx, output, $clog2(NUM_CH), the channel index of Data_Out.
REQ-011 SHALL have port Valid_Out, output, 1, Data_Out/Ch_Idx/Last_Out valid.
REQ-012 SHALL have port Ready_In, input, 1, downstream accepts this cycle.
REQ-013 SHALL have port Last_Out, output, 1, last channel of last pixel of a frame.
REQ-014 SHALL have port Overflow, output, 1, sticky flag set when an input word was dropped.
REQ-015 SHALL have port Busy, output, 1, high while the FIFO holds at least one word.

Function
REQ-016 SHALL store each Valid_In word into the FIFO tail when the FIFO is not full, or when it is full but a pop occurs in the same cycle.
REQ-017 SHALL drop Valid_In words arriving when the FIFO is full with no same-cycle pop, set Overflow, and leave the FIFO contents and pointers unchanged.
REQ-018 SHALL define a transfer as Valid_Out && Ready_In on a rising edge.
REQ-019 SHALL drive Valid_Out = (FIFO count != 0), giving a latency of one cycle from a Valid_In write edge to Valid_Out high.
REQ-020 SHALL drive Data_Out from channel Ch_Idx of the FIFO head word.
REQ-021 SHALL hold Data_Out, Ch_Idx and Last_Out stable while Valid_Out is high and Ready_In is low.
REQ-022 SHALL advance Ch_Idx by 1 on each transfer; on a transfer with Ch_Idx = NUM_CH-1 it SHALL pop the head word and wrap Ch_Idx to 0.
REQ-023 SHALL keep a pixel counter 0..PIX-1 that increments on each pop and wraps to 0 after PIX-1.
REQ-024 SHALL drive Last_Out = Valid_Out && Ch_Idx==NUM_CH-1 && pixel counter==PIX-1.
REQ-025 SHALL implement a state machine IDLE (count 0) -> STREAM on the first write; STREAM -> IDLE when a pop empties the FIFO with no same-cycle write; otherwise it SHALL remain in STREAM.
REQ-026 SHALL update count as count+1 on write only, count-1 on pop only, and leave count unchanged on a simultaneous write and pop; count SHALL never exceed FIFO_DEPTH.
REQ-027 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-028 SHALL drive Busy = (state == STREAM).
REQ-029 SHALL never set Overflow when Ready_In stays high, given a NUM_CH-cycle input spacing or a burst of at most FIFO_DEPTH words.

Reset
REQ-030 SHALL, while rst=0, immediately clear FIFO count, pointers, Ch_Idx, pixel counter, Overflow and Busy, force state IDLE, and drive Valid_Out=0 and Last_Out=0; Data_Out value is don't-care.
REQ-031 SHALL discard all buffered words on reset asserted mid-frame; after release the next accepted word SHALL be pixel 0, channel 0.
REQ-032 SHALL clear Overflow only by reset.

Verification
REQ-033 SHALL verify single word: one write of channels {0..7 = 0x10..0x17} with Ready_In=1 -> Valid_Out high one cycle later, Data_Out 0x10..0x17, Ch_Idx 0..7 over 8 cycles, then Busy=0.
REQ-034 SHALL verify backpressure: Ready_In=0 for 5 cycles at Ch_Idx=3 -> Data_Out=0x13 and Ch_Idx=3 held, no sample lost or duplicated.
REQ-035 SHALL verify overflow: 6 back-to-back writes with Ready_In=0 and FIFO_DEPTH=4 -> words 5 and 6 dropped, Overflow=1 sticky, the 4 stored words emitted intact.
REQ-036 SHALL verify full with pop: FIFO full and a write on the same edge as a pop of channel 7 -> write accepted, count stays 4, Overflow stays 0.
REQ-037 SHALL verify frame boundary: 1936 words streamed -> Last_Out high only on the 15488th transfer; pixel counter back to 0 after it; the next frame's first sample has Ch_Idx=0.
REQ-038 SHALL verify mid-frame reset: rst low while the FIFO holds 3 words at Ch_Idx=5 -> Valid_Out=0 and Busy=0 immediately; after release a new word starts at Ch_Idx=0 and pixel 0.
